// File: rtl/sonar_scan_if.sv
// -----------------------------------------------------------------------------
// sonar_scan_if
// Purpose : bundles the command channel (host -> sonar block) and the result
//           channel (sonar block -> host) of sonar_scan.
// Signals : in_ctrl[3:0]   command code
//           in_data[23:0]  command argument
//           in_wr          command strobe, one cycle per command
//           out_ctrl[3:0]  [2:0] channel index of the result, [3] always 0
//           out_data[23:0] [WIDTH-1:0] measurement, [23] timeout/overflow flag
//           out_wr         result valid
//           out_wr_rdy     result accepted
// Modports: slave  - the sonar block (takes commands, offers results)
//           master - the host side (issues commands, accepts results)
//
// Handshake: in_wr is a fire-and-forget strobe with no back-pressure; every
// cycle with in_wr=1 is one command. On the result side out_wr is the valid
// and out_wr_rdy the ready: once out_wr rises, out_ctrl/out_data hold stable
// until the cycle where out_wr=1 and out_wr_rdy=1, which completes the
// transfer. out_wr never depends combinationally on out_wr_rdy.
// -----------------------------------------------------------------------------
interface sonar_scan_if;
  logic [3:0]  in_ctrl;
  logic [23:0] in_data;
  logic        in_wr;
  logic [3:0]  out_ctrl;
  logic [23:0] out_data;
  logic        out_wr;
  logic        out_wr_rdy;

  modport slave (
    input  in_ctrl, in_data, in_wr, out_wr_rdy,
    output out_ctrl, out_data, out_wr
  );

  modport master (
    output in_ctrl, in_data, in_wr, out_wr_rdy,
    input  out_ctrl, out_data, out_wr
  );
endinterface

// File: rtl/sonar_scan.sv
// -----------------------------------------------------------------------------
// sonar_scan
// Purpose : drives up to 8 HC-SR04 ultrasonic rangers, measures each echo
//           pulse with a prescaled saturating counter and reports results
//           over a valid/ready result channel with round-robin arbitration.
// Optional: define SONAR_SCAN_AUTO_EN to build the autonomous round-robin scan
//           scheduler (in_ctrl=1 load mask/gap, in_ctrl=2 stop). Without it
//           only single-shot commands (in_ctrl=0) are honoured.
// Ports   : clk           system clock
//           rst           synchronous active-high reset
//           hc04_echo     raw asynchronous echo lines, one per channel
//           hc04_trigger  registered trigger lines, one per channel
//           o_dbg_state   per-channel FSM state, 2 bits per channel
//           bus           sonar_scan_if.slave (command + result channels)
// -----------------------------------------------------------------------------
module sonar_scan #(
  parameter int CHANNELS    = 6,
  parameter int WIDTH       = 12,
  parameter int PREDIV      = 5,
  parameter int TRIG_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   hc04_echo,
  output logic [CHANNELS-1:0]   hc04_trigger,
  output logic [2*CHANNELS-1:0] o_dbg_state,
  sonar_scan_if.slave           bus
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam logic [TW-1:0]    TLOAD = TW'(TRIG_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAXV  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAXM1 = {{(WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS} ch_state_t;

  ch_state_t         r_state   [CHANNELS];
  logic [TW-1:0]     r_tcnt    [CHANNELS];
  logic [WIDTH-1:0]  r_cnt     [CHANNELS];
  logic [WIDTH-1:0]  r_res_val [CHANNELS];
  logic [CHANNELS-1:0] r_res_flag, r_pend, r_trig;
  logic [CHANNELS-1:0] r_echo_s1, r_echo_s2, r_echo_s3;
  logic [PREDIV-1:0] r_presc;
  logic [CW-1:0]     r_last;
  logic              r_out_wr;
  logic [3:0]        r_out_ctrl;
  logic [23:0]       r_out_data;

  logic                w_tick, w_xfer, w_gnt_v;
  logic [CW-1:0]       w_gnt;
  logic [CHANNELS-1:0] w_rise, w_cmd_start, w_scan_start, w_start, w_rep, w_rep_flag;
  logic [WIDTH-1:0]    w_rep_val [CHANNELS];
  logic                w_unused_bits;

  assign w_unused_bits = ^{bus.in_data, bus.in_ctrl};

  assign w_tick      = (r_presc == '0);
  assign w_rise      = r_echo_s2 & ~r_echo_s3;
  assign w_xfer      = r_out_wr & bus.out_wr_rdy;
  assign w_cmd_start = (bus.in_wr && bus.in_ctrl == 4'd0) ? bus.in_data[CHANNELS-1:0] : '0;
  assign w_start     = w_cmd_start | w_scan_start;

  assign hc04_trigger = r_trig;
  assign bus.out_wr   = r_out_wr;
  assign bus.out_ctrl = r_out_ctrl;
  assign bus.out_data = r_out_data;

  always_comb begin
    o_dbg_state = '0;
    for (int i = 0; i < CHANNELS; i++) o_dbg_state[2*i +: 2] = r_state[i];
  end

  // Echo synchroniser (s1/s2) plus one extra stage to find the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_echo_s1 <= '0;
      r_echo_s2 <= '0;
      r_echo_s3 <= '0;
      r_presc   <= '0;
    end else begin
      r_echo_s1 <= hc04_echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_s3 <= r_echo_s2;
      r_presc   <= r_presc + 1'b1;
    end
  end

  // Result reports: a timeout after 2^WIDTH-1 idle ticks, or the echo fall.
  // A count that reached all-ones is an overflow and carries the flag.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_rep[i]      = 1'b0;
      w_rep_val[i]  = MAXV;
      w_rep_flag[i] = 1'b1;
      if (r_state[i] == S_WAIT && !w_rise[i] && w_tick && r_cnt[i] == MAXM1) begin
        w_rep[i] = 1'b1;
      end else if (r_state[i] == S_MEAS && !r_echo_s2[i]) begin
        w_rep[i]      = 1'b1;
        w_rep_val[i]  = r_cnt[i];
        w_rep_flag[i] = (r_cnt[i] == MAXV);
      end
    end
  end

  // Channel FSMs and the result store with its pending bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i]   <= S_IDLE;
        r_tcnt[i]    <= '0;
        r_cnt[i]     <= '0;
        r_res_val[i] <= '0;
      end
      r_res_flag <= '0;
      r_pend     <= '0;
      r_trig     <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        case (r_state[i])
          S_IDLE: if (w_start[i]) begin
            r_state[i] <= S_TRIG;
            r_trig[i]  <= 1'b1;
            r_tcnt[i]  <= TLOAD;
          end
          S_TRIG: if (r_tcnt[i] == '0) begin
            r_state[i] <= S_WAIT;
            r_trig[i]  <= 1'b0;
            r_cnt[i]   <= '0;
          end else begin
            r_tcnt[i] <= r_tcnt[i] - 1'b1;
          end
          // The tick coinciding with the rise is counted so a pulse of
          // N*2^PREDIV clocks always measures N regardless of prescaler phase.
          S_WAIT: if (w_rise[i]) begin
            r_state[i] <= S_MEAS;
            r_cnt[i]   <= {{(WIDTH-1){1'b0}}, w_tick};
          end else if (w_rep[i]) begin
            r_state[i] <= S_IDLE;
          end else if (w_tick) begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
          S_MEAS: if (w_rep[i]) begin
            r_state[i] <= S_IDLE;
          end else if (w_tick && r_cnt[i] != MAXV) begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
          default: r_state[i] <= S_IDLE;
        endcase

        // A report landing in the acceptance cycle keeps the bit set.
        if (w_rep[i]) begin
          r_res_val[i]  <= w_rep_val[i];
          r_res_flag[i] <= w_rep_flag[i];
          r_pend[i]     <= 1'b1;
        end else if (w_xfer && r_last == CW'(i)) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin : p_rr
    int v_idx;
    v_idx   = 0;
    w_gnt_v = 1'b0;
    w_gnt   = r_last;
    for (int k = 1; k <= CHANNELS; k++) begin
      v_idx = int'(r_last) + k;
      if (v_idx >= CHANNELS) v_idx = v_idx - CHANNELS;
      if (!w_gnt_v && r_pend[CW'(v_idx)]) begin
        w_gnt_v = 1'b1;
        w_gnt   = CW'(v_idx);
      end
    end
  end

  // Output register: data is latched at grant, so later overwrites of the
  // store cannot disturb a transfer in progress. Dropping out_wr after each
  // accepted transfer guarantees an idle cycle before the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_wr   <= 1'b0;
      r_out_ctrl <= '0;
      r_out_data <= '0;
      r_last     <= CW'(CHANNELS - 1);
    end else if (r_out_wr) begin
      if (bus.out_wr_rdy) r_out_wr <= 1'b0;
    end else if (w_gnt_v) begin
      r_out_wr   <= 1'b1;
      r_last     <= w_gnt;
      r_out_ctrl <= {1'b0, 3'(w_gnt)};
      r_out_data <= {r_res_flag[w_gnt], {(23-WIDTH){1'b0}}, r_res_val[w_gnt]};
    end
  end

`ifdef SONAR_SCAN_AUTO_EN
  logic [CHANNELS-1:0] r_mask;
  logic [15:0]         r_gap, r_gap_cnt;
  logic [CW-1:0]       r_ptr, r_prev;
  logic                r_prev_v;
  logic                w_prev_idle, w_sel_v, w_fire;
  logic [CW-1:0]       w_sel;

  // Next masked channel in ascending order after the scan pointer; a lone
  // mask bit selects its own channel again.
  always_comb begin : p_scan_sel
    int v_idx;
    v_idx   = 0;
    w_sel_v = 1'b0;
    w_sel   = r_ptr;
    for (int k = 1; k <= CHANNELS; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= CHANNELS) v_idx = v_idx - CHANNELS;
      if (!w_sel_v && r_mask[CW'(v_idx)]) begin
        w_sel_v = 1'b1;
        w_sel   = CW'(v_idx);
      end
    end
  end

  assign w_prev_idle = !r_prev_v || (r_state[r_prev] == S_IDLE);
  assign w_fire      = w_prev_idle && (r_gap_cnt == 16'd0) && w_sel_v;

  always_comb begin
    w_scan_start = '0;
    if (w_fire && r_state[w_sel] == S_IDLE) w_scan_start[w_sel] = 1'b1;
  end

  // The gap counter is held at the programmed gap while the previously
  // scanned channel is busy and counts ticks down once it is back in IDLE.
  // A selected channel that is busy is stepped over without waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask    <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_ptr     <= CW'(CHANNELS - 1);
      r_prev    <= '0;
      r_prev_v  <= 1'b0;
    end else begin
      if (bus.in_wr && bus.in_ctrl == 4'd1) begin
        r_mask <= bus.in_data[CHANNELS-1:0];
        r_gap  <= bus.in_data[23:8];
      end else if (bus.in_wr && bus.in_ctrl == 4'd2) begin
        r_mask <= '0;
      end

      if (!w_prev_idle) r_gap_cnt <= r_gap;
      else if (r_gap_cnt != 16'd0 && w_tick) r_gap_cnt <= r_gap_cnt - 1'b1;

      if (w_fire) begin
        r_ptr <= w_sel;
        if (r_state[w_sel] == S_IDLE) begin
          r_prev   <= w_sel;
          r_prev_v <= 1'b1;
        end
      end
    end
  end
`else
  assign w_scan_start = '0;
`endif

endmodule

// File: tb/tb_sonar_scan.sv
// -----------------------------------------------------------------------------
// tb_sonar_scan
// Bench for sonar_scan built with CHANNELS=6, WIDTH=6, PREDIV=5,
// TRIG_CYCLES=1023 so that timeouts/overflows (63 ticks) stay short.
// -----------------------------------------------------------------------------
module tb_sonar_scan;
  localparam int CHANNELS    = 6;
  localparam int WIDTH       = 6;
  localparam int PREDIV      = 5;
  localparam int TRIG_CYCLES = 1023;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [CHANNELS-1:0]   echo = '0;
  logic [CHANNELS-1:0]   trig;
  logic [2*CHANNELS-1:0] dbg;
  int                    cyc = 0;
  int                    checks = 0;
  int                    errors = 0;
  logic [27:0]           exp_q[$];

  sonar_scan_if bus();

  sonar_scan #(
    .CHANNELS(CHANNELS), .WIDTH(WIDTH), .PREDIV(PREDIV), .TRIG_CYCLES(TRIG_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .hc04_echo(echo), .hc04_trigger(trig),
    .o_dbg_state(dbg), .bus(bus)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int          ch;
    int          len;      // echo high time in clocks, 0 = no echo
    logic [3:0]  exp_ctrl;
    logic [23:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; echo = '0;
    bus.in_wr = 1'b0; bus.out_wr_rdy = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [3:0] c, input logic [23:0] d);
    bus.in_ctrl = c; bus.in_data = d; bus.in_wr = 1'b1;
    step();
    bus.in_wr = 1'b0;
  endtask

  task automatic wait_out(input string name, input int bound);
    int n;
    n = 0;
    while (!bus.out_wr && n < bound) begin step(); n++; end
    check(name, {31'd0, bus.out_wr}, 32'd1);
  endtask

  task automatic wait_trig_low(input int ch);
    int n;
    n = 0;
    while (trig[ch] && n < 1100) begin step(); n++; end
  endtask

  task automatic accept();
    bus.out_wr_rdy = 1'b1;
    step();
    bus.out_wr_rdy = 1'b0;
  endtask

  initial begin
    int n, seen, d, idle_cyc;
    logic [27:0] held;
    int order[4];

    vecs[0] = '{ch: 0, len: 320,  exp_ctrl: 4'd0, exp_data: 24'h00000A};
    vecs[1] = '{ch: 3, len: 96,   exp_ctrl: 4'd3, exp_data: 24'h000003};
    vecs[2] = '{ch: 5, len: 1984, exp_ctrl: 4'd5, exp_data: 24'h00003E};
    vecs[3] = '{ch: 4, len: 2016, exp_ctrl: 4'd4, exp_data: 24'h80003F};
    vecs[4] = '{ch: 1, len: 0,    exp_ctrl: 4'd1, exp_data: 24'h80003F};
    vecs[5] = '{ch: 2, len: 2500, exp_ctrl: 4'd2, exp_data: 24'h80003F};
    vecs[6] = '{ch: 0, len: 32,   exp_ctrl: 4'd0, exp_data: 24'h000001};

    bus.in_ctrl = '0; bus.in_data = '0; bus.in_wr = 1'b0; bus.out_wr_rdy = 1'b0;
    do_reset();
    step();

    // Reset state
    check("rst_trig", trig, 0);
    check("rst_out_wr", bus.out_wr, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_ctrl", bus.out_ctrl, 0);
    check("rst_fsm_idle", dbg, 0);

    // Unknown command code is ignored
    send_cmd(4'd7, 24'h00003F);
    repeat (5) step();
    check("bad_cmd_no_trig", trig, 0);

    // Table of single-shot measurements
    for (int v = 0; v < 7; v++) begin
      send_cmd(4'd0, 24'(1 << vecs[v].ch));
      check($sformatf("v%0d_trig_rise", v), trig, 1 << vecs[v].ch);
      n = 0;
      while (trig[vecs[v].ch] && n < 2000) begin step(); n++; end
      check($sformatf("v%0d_trig_len", v), n, TRIG_CYCLES);
      seen = 0;
      for (int k = 0; k < vecs[v].len; k++) begin
        echo[vecs[v].ch] = 1'b1;
        step();
        if (bus.out_wr) seen++;
      end
      echo[vecs[v].ch] = 1'b0;
      check($sformatf("v%0d_no_early_out", v), seen, 0);
      wait_out($sformatf("v%0d_out_wr", v), 2300);
      check($sformatf("v%0d_ctrl", v), bus.out_ctrl, vecs[v].exp_ctrl);
      check($sformatf("v%0d_data", v), bus.out_data, vecs[v].exp_data);
      accept();
      check($sformatf("v%0d_out_wr_drop", v), bus.out_wr, 0);
    end

    // Two results in the same cycle, ready held low: ch0 then ch2
    do_reset();
    send_cmd(4'd0, 24'h000005);
    check("dual_trig", trig, 6'h05);
    wait_trig_low(0);
    exp_q.push_back({4'd0, 24'd5});
    exp_q.push_back({4'd2, 24'd5});
    echo = 6'h05;
    repeat (160) step();
    echo = '0;
    wait_out("dual_first_wr", 50);
    check("dual_first", {bus.out_ctrl, bus.out_data}, exp_q[0]);
    held = {bus.out_ctrl, bus.out_data};
    seen = 0;
    repeat (50) begin
      step();
      if (!bus.out_wr || {bus.out_ctrl, bus.out_data} !== held) seen++;
    end
    check("dual_hold_stable", seen, 0);
    void'(exp_q.pop_front());
    accept();
    check("dual_gap_cycle", bus.out_wr, 0);
    step();
    check("dual_second_wr", bus.out_wr, 1);
    check("dual_second", {bus.out_ctrl, bus.out_data}, exp_q.pop_front());
    accept();
    check("dual_queue_empty", exp_q.size(), 0);

    // Reset mid-measurement with a result pending
    do_reset();
    send_cmd(4'd0, 24'h000003);
    wait_trig_low(0);
    echo = 6'h03;
    repeat (64) step();
    echo[1] = 1'b0;
    wait_out("rstm_wr", 50);
    check("rstm_ctrl", bus.out_ctrl, 1);
    check("rstm_data", bus.out_data, 2);
    check("rstm_ch0_measuring", dbg[1:0], 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstm_out_wr", bus.out_wr, 0);
    check("rstm_out_data", bus.out_data, 0);
    check("rstm_out_ctrl", bus.out_ctrl, 0);
    check("rstm_trig", trig, 0);
    check("rstm_fsm_idle", dbg, 0);
    echo = '0;
    bus.out_wr_rdy = 1'b1;
    seen = 0;
    repeat (300) begin step(); if (bus.out_wr) seen++; end
    bus.out_wr_rdy = 1'b0;
    check("rstm_no_stale", seen, 0);

`ifdef SONAR_SCAN_AUTO_EN
    // Scan mask 0x0B, gap 4 ticks: order 0,1,3,0 then stop
    order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0;
    idle_cyc = 0;
    do_reset();
    bus.out_wr_rdy = 1'b1;
    send_cmd(4'd1, {16'd4, 8'h0B});
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (trig == '0 && n < 3000) begin step(); n++; end
      check($sformatf("scan%0d_ch", k), trig, 1 << order[k]);
      if (k > 0) begin
        d = cyc - idle_cyc;
        if (d < 96 || d > 132) $display("scan%0d gap %0d clocks", k, d);
        check($sformatf("scan%0d_gap", k), (d >= 96 && d <= 132), 1);
      end
      if (k == 3) send_cmd(4'd2, 24'd0);
      wait_trig_low(order[k]);
      echo[order[k]] = 1'b1;
      repeat (64) step();
      echo[order[k]] = 1'b0;
      n = 0;
      while (dbg[2*order[k] +: 2] != 2'd0 && n < 50) begin step(); n++; end
      idle_cyc = cyc;
    end
    seen = 0;
    repeat (1500) begin step(); if (trig != '0) seen++; end
    check("scan_stopped", seen, 0);
    bus.out_wr_rdy = 1'b0;
`else
    // Without the scan build, mask load is ignored
    send_cmd(4'd1, {16'd0, 8'h01});
    seen = 0;
    repeat (200) begin step(); if (trig != '0) seen++; end
    check("noscan_ignored", seen, 0);
`endif

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sonar_scan.md
# sonar_scan

Parametrised successor to the fixed six-channel HC-SR04 sonar block. It drives up to 8 ultrasonic rangers and measures each echo pulse with a prescaled, saturating counter. It reports results over the standard ctrl/data write/read channel pair. It adds an optional autonomous round-robin scan mode, echo timeout and overflow flagging, and a held-until-accepted output handshake.

## Interface
- CHANNELS, 6: number of rangers, 1..8.
- WIDTH, 12: measurement width, 4..16.
- PREDIV, 5: counter ticks once every 2^PREDIV clocks.
- TRIG_CYCLES, 1023: trigger pulse length in clocks, ≥1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- hc04_echo  in  CHANNELS  raw echo lines, asynchronous.
- hc04_trigger  out  CHANNELS  trigger lines to rangers.
- in_ctrl  in  4  command code.
- in_data  in  24  command argument.
- in_wr  in  1  command strobe, one cycle per command.
- out_ctrl  out  4  [2:0] channel index, [3] = 0.
- out_data  out  24  [WIDTH-1:0] value, [23] flag, others 0.
- out_wr  out  1  result valid.
- out_wr_rdy  in  1  result accepted.

## Operation
- Commands are sampled when in_wr=1:
  - in_ctrl=0: single shot. Trigger every channel i with in_data[i]=1 whose FSM is IDLE. Bits for busy channels are ignored.
  - in_ctrl=1: load scan mask in_data[7:0] and scan gap in_data[23:8]. The gap is counted in prescaled ticks.
  - in_ctrl=2: stop scan (mask cleared). Measurements already in flight complete normally.
  - Any other code is ignored.
- Mask bits ≥ CHANNELS are ignored.
- Echo inputs pass through a 2-flop synchroniser.
- Each channel runs its own FSM:
  - IDLE -> TRIG on trigger.
  - TRIG: hc04_trigger[i]=1 for exactly TRIG_CYCLES clocks -> WAIT_RISE.
  - WAIT_RISE: on synced echo rise, clear the counter -> MEASURE. If 2^WIDTH-1 ticks elapse with no rise, report value all-ones with flag=1 -> IDLE.
  - MEASURE: the counter increments on each prescale tick. On echo fall, report the count with flag=0 -> IDLE. On reaching 2^WIDTH-1, hold the count and set overflow; on the eventual fall, report all-ones with flag=1.
- The prescaler is a free-running PREDIV-bit counter shared by all channels. A tick occurs when it wraps to 0.
- Result store: one register plus one pending bit per channel.
  - A new result overwrites an unread result; pending stays set. The newest result always wins.
- Output arbiter: round-robin over pending bits, searching from (last granted + 1) mod CHANNELS.
  - The granted channel's result is latched into out_data/out_ctrl and out_wr is raised.
  - Data holds stable while out_wr=1, even if the store is overwritten meanwhile.
  - A transfer completes in the cycle where out_wr=1 and out_wr_rdy=1. The pending bit clears unless a new result for that same channel lands in the same cycle; that new result stays pending.
- Scan (when compiled in): a scheduler walks set mask bits in ascending index order, wrapping. It triggers the next channel only when:
  - the previous scanned channel is IDLE, and
  - the gap counter has expired.
- A mask change takes effect at the next channel selection.
- While scanning, single-shot commands still apply to IDLE channels. A channel that is busy when the scheduler reaches it is skipped.

## Timing
- Reset values:
  - hc04_trigger=0, out_wr=0, out_data=0, out_ctrl=0.
  - All FSMs IDLE, pending=0, scan mask=0, arbiter pointer=CHANNELS-1.
- Reset mid-measurement aborts it; no result is reported.
- Command to trigger: hc04_trigger rises the clock after the in_wr cycle.
- Echo to FSM: 2 clocks of synchroniser latency.
- Result to output: report in cycle N sets pending in N+1. out_wr rises in N+2 if the output is free.
- Handshake: after an accepted transfer, out_wr=0 for at least one cycle before the next grant.
- Scan: a trigger is issued the cycle after the gap expires. The gap counter starts when the previous channel returns to IDLE. Gap 0 means back-to-back triggering.
- Single-channel mask: that channel re-triggers repeatedly, separated by the gap.

## Configuration
- SONAR_SCAN_AUTO_EN defined: scheduler, mask and gap registers present; in_ctrl=1 and in_ctrl=2 are honoured.
- Not defined: single-shot only. in_ctrl=1 and in_ctrl=2 are ignored and no scheduler logic is synthesised.

## Test plan
- Reset, then single shot in_data=0x01; echo ch0 high for 320 clocks (PREDIV=5) -> trigger high for 1023 clocks, then out_wr with out_ctrl=0, out_data=10, flag 0.
- Single shot 0x05 with both echoes completing the same cycle, out_wr_rdy held low for 50 cycles -> ch0 presented first and held stable; ch2 presented after acceptance and ≥1 idle cycle.
- Single shot 0x02 with no echo -> after 4095 ticks, out_ctrl=1, out_data[11:0]=0xFFF, bit23=1.
- Echo held high past 4095 ticks then released -> one result 0xFFF, flag 1; no intermediate report.
- Scan mask 0x0B, gap 4 (SONAR_SCAN_AUTO_EN) -> trigger order 0,1,3,0,… with each trigger starting 4 ticks + 1 clock after the previous channel returns to IDLE. Stop command -> no new triggers.
- Assert rst mid-MEASURE with a result pending -> all outputs 0 next cycle; no stale result appears afterwards.
